// File: rtl/uart_pkg.sv
// Shared UART types and constants for the baud-rate generator and its helpers.
package uart_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_W_DEF  = 5;

  typedef logic [DIV_W_DEF-1:0]  div_int_t;
  typedef logic [FRAC_W_DEF-1:0] div_frac_t;
  typedef logic [OVS_W_DEF-1:0]  ovs_ratio_t;

  // Oversample ratio-1 encodings
  localparam int OVS_16X = 15;
  localparam int OVS_8X  = 7;

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional-divisor accumulator: adds the shadow fraction on every prescale
// wrap and exposes the carry, which stretches the following period by one cycle.
module baud_frac_accum
  import uart_pkg::*;
#(
  parameter int FRAC_WIDTH = FRAC_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wrap_i,
  input  logic                  clr_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output logic                  carry_q
);

  logic [FRAC_WIDTH-1:0] acc_q;

  // Accumulate on wrap; clear restarts the fractional phase from zero
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (clr_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (wrap_i) begin
      {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, frac_i};
    end
  end

endmodule

// File: rtl/baud_rate_generator_frac.sv
// Fractional baud-rate generator: a prescaler produces the oversample tick,
// an ovs counter divides that down to the per-bit baud tick. Divisor and
// oversample ratio are shadowed and only taken on a load pulse.
// Build option: define FRACTIONAL_DIV_EN to add the fractional accumulator;
// without it the divider is integer-only and div_frac_i is ignored.
module baud_rate_generator_frac
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_W_DEF,
  parameter int FRAC_WIDTH  = FRAC_W_DEF,
  parameter int OVS_WIDTH   = OVS_W_DEF,
  parameter int RST_DIV_INT = 26,
  parameter int RST_OVS     = OVS_16X
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [DIV_WIDTH-1:0]  div_int_i,
  input  logic [FRAC_WIDTH-1:0] div_frac_i,
  input  logic [OVS_WIDTH-1:0]  ovs_ratio_i,
  output logic                  ov_baud_rt_o,
  output logic                  baud_rt_o
);

  logic [DIV_WIDTH-1:0] div_int_q;
  logic [OVS_WIDTH-1:0] ovs_q;
  logic [DIV_WIDTH:0]   pre_cnt_q;
  logic [OVS_WIDTH-1:0] ovs_cnt_q;
  logic                 carry_q;

  logic [DIV_WIDTH:0]   period;
  logic                 at_period;
  logic                 ovs_last;
  logic                 ov_hit;
  logic                 baud_hit;

  // One extra counter bit so div_int=all-ones plus a carry still fits
  assign period    = {1'b0, div_int_q} + {{DIV_WIDTH{1'b0}}, carry_q};
  assign at_period = (pre_cnt_q == period);
  assign ovs_last  = (ovs_cnt_q == ovs_q);
  // A load in the tick cycle wins and suppresses the tick
  assign ov_hit    = enable_i & at_period & ~load_i;
  assign baud_hit  = ov_hit & ovs_last;

  // Shadow divisor and oversample ratio, captured only on load
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_int_q <= DIV_WIDTH'(RST_DIV_INT);
      ovs_q     <= OVS_WIDTH'(RST_OVS);
    end else if (load_i) begin
      div_int_q <= div_int_i;
      ovs_q     <= ovs_ratio_i;
    end
  end

  // Prescale counter: 0..period, holds while disabled
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || load_i) begin
      pre_cnt_q <= '0;
    end else if (enable_i) begin
      if (at_period) pre_cnt_q <= '0;
      else           pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end

  // Oversample counter: advances per ov tick, wraps after ovs_q
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || load_i) begin
      ovs_cnt_q <= '0;
    end else if (ov_hit) begin
      if (ovs_last) ovs_cnt_q <= '0;
      else          ovs_cnt_q <= ovs_cnt_q + 1'b1;
    end
  end

  // Registered tick outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ov_baud_rt_o <= 1'b0;
      baud_rt_o    <= 1'b0;
    end else begin
      ov_baud_rt_o <= ov_hit;
      baud_rt_o    <= baud_hit;
    end
  end

`ifdef FRACTIONAL_DIV_EN
  logic [FRAC_WIDTH-1:0] div_frac_q;

  // Shadow fraction, captured only on load
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)    div_frac_q <= '0;
    else if (load_i) div_frac_q <= div_frac_i;
  end

  baud_frac_accum #(
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac_accum (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wrap_i  (ov_hit),
    .clr_i   (load_i),
    .frac_i  (div_frac_q),
    .carry_q (carry_q)
  );
`else
  // Integer-only divider: fraction input is deliberately ignored
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac_i;
  assign carry_q         = 1'b0;
`endif

endmodule
